// File: rtl/counter_ctrl.sv
// CPU-side register window for the three-channel down-counter: decodes loads/stores, drives load strobe/value/channel, reads counts back.
// Latency (request cycle to cpu_ready, inclusive): CTRL/miss 2, count write WE_HOLD+2, count read RD_WAIT+2.
// Backpressure: the CPU holds mem_w/mem_r and stalls until the one-cycle cpu_ready pulse; requests are only accepted in IDLE.
module counter_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int unsigned WE_HOLD   = 4,
  parameter int unsigned RD_WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic        mem_r,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        cpu_ready,
  output logic        counter_we,
  output logic [31:0] counter_val,
  output logic [1:0]  counter_ch,
  input  logic [31:0] counter_out,
  input  logic        counter0_out,
  input  logic        counter1_out,
  input  logic        counter2_out,
  output logic        irq
);

  typedef enum logic [2:0] {IDLE, LOAD, RSEL, RWAIT, DONE} state_t;

  // Down-counters hold (remaining cycles - 1) so the exit test is cnt == 0.
  localparam logic [3:0] WE_CNT = 4'(WE_HOLD - 1);
  localparam logic [3:0] RD_CNT = 4'(RD_WAIT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] val_nxt, dout_nxt;
  logic [1:0]  ch_nxt;
  logic [2:0]  enable, enable_nxt;
  logic [2:0]  pending, pending_nxt;
  logic [2:0]  hist, flags, clr;
  logic        hit, is_ctrl;
  logic        unused_addr_lsb;

  assign hit             = (addr[31:4] == BASE_ADDR[31:4]);
  assign is_ctrl         = (addr[3:2] == 2'd3);
  assign flags           = {counter2_out, counter1_out, counter0_out};
  assign unused_addr_lsb = ^addr[1:0];

  // Next-state, datapath and interrupt-pending logic.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    val_nxt    = counter_val;
    ch_nxt     = counter_ch;
    dout_nxt   = data_out;
    enable_nxt = enable;
    clr        = 3'b000;
    case (state)
      IDLE: begin
        if (mem_w || mem_r) begin
          if (!hit) begin
            dout_nxt  = 32'd0;
            state_nxt = DONE;
          end else if (mem_w) begin
            // A simultaneous read request is treated as a write.
            if (is_ctrl) begin
              enable_nxt = data_in[2:0];
              clr        = data_in[6:4];
              state_nxt  = DONE;
            end else begin
              val_nxt   = data_in;
              ch_nxt    = addr[3:2];
              cnt_nxt   = WE_CNT;
              state_nxt = LOAD;
            end
          end else if (is_ctrl) begin
            dout_nxt  = {25'd0, pending, 1'b0, enable};
            state_nxt = DONE;
          end else begin
            ch_nxt    = addr[3:2];
            cnt_nxt   = RD_CNT;
            state_nxt = RSEL;
          end
        end
      end
      LOAD: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RSEL, RWAIT: begin
        if (cnt == 4'd0) begin
          dout_nxt  = counter_out;
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt - 4'd1;
          state_nxt = RWAIT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A rising zero flag beats a same-cycle write-1-to-clear.
    pending_nxt = (pending & ~clr) | (flags & ~hist);
  end

  // State and datapath registers; reset returns everything to idle at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      counter_val <= 32'd0;
      counter_ch  <= 2'd0;
      data_out    <= 32'd0;
      enable      <= 3'b000;
      pending     <= 3'b000;
      hist        <= 3'b000;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      counter_val <= val_nxt;
      counter_ch  <= ch_nxt;
      data_out    <= dout_nxt;
      enable      <= enable_nxt;
      pending     <= pending_nxt;
      hist        <= flags;
    end
  end

  // Strobes decode straight from the state register so reset kills them immediately.
  assign counter_we = (state == LOAD);
  assign cpu_ready  = (state == DONE);
  assign irq        = |(pending & enable);

endmodule

// File: tb/tb_counter_ctrl.sv
// Randomized bench for counter_ctrl against a transaction-level reference model.
// Latency: checks each access end to end. Backpressure: holds requests until cpu_ready, sometimes drops them early.
module tb_counter_ctrl;

  localparam logic [31:0] BASE    = 32'hFFFF_FF00;
  localparam int          WE_HOLD = 4;
  localparam int          RD_WAIT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_w = 1'b0, mem_r = 1'b0;
  logic [31:0] addr = '0, data_in = '0;
  logic [31:0] data_out, counter_val, counter_out;
  logic        cpu_ready, counter_we, irq;
  logic [1:0]  counter_ch;
  logic [2:0]  flg = 3'b000;
  logic [31:0] chan_val [4];

  int total = 0;
  int bad   = 0;

  // Reference state: pending/enable/flag history and the last returned load data.
  logic [2:0]  mdl_pend = '0, mdl_en = '0, mdl_hist = '0, mdl_clr = '0, mdl_en_new = '0;
  logic        mdl_en_wr = 1'b0;
  logic [31:0] mdl_dout = '0;
  bit          rand_flags = 1'b0;
  logic [31:0] base_v = BASE;

  assign counter_out = chan_val[counter_ch];

  always #5 clk = ~clk;

  counter_ctrl #(.BASE_ADDR(BASE), .WE_HOLD(WE_HOLD), .RD_WAIT(RD_WAIT)) dut (
    .clk(clk), .reset(reset), .mem_w(mem_w), .mem_r(mem_r), .addr(addr),
    .data_in(data_in), .data_out(data_out), .cpu_ready(cpu_ready),
    .counter_we(counter_we), .counter_val(counter_val), .counter_ch(counter_ch),
    .counter_out(counter_out), .counter0_out(flg[0]), .counter1_out(flg[1]),
    .counter2_out(flg[2]), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: update the interrupt model at the edge, check irq at the falling edge.
  task automatic tick();
    logic [2:0] f;
    @(posedge clk);
    f = flg;
    if (!reset) begin
      mdl_pend = '0; mdl_en = '0; mdl_hist = '0; mdl_dout = '0;
    end else begin
      mdl_pend = (mdl_pend & ~mdl_clr) | (f & ~mdl_hist);
      mdl_hist = f;
      if (mdl_en_wr) mdl_en = mdl_en_new;
    end
    mdl_clr = '0;
    mdl_en_wr = 1'b0;
    @(negedge clk);
    chk("irq", 32'(irq), 32'(|(mdl_pend & mdl_en)));
    if (rand_flags)
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 5) == 0) flg[i] = ~flg[i];
  endtask

  // One CPU access, called at a falling edge with the DUT idle.
  task automatic access(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input bit drop);
    bit          hit;
    int          ofs, exp_lat, exp_we, n, we_cnt;
    logic [31:0] exp_dout;
    hit      = (a[31:4] == base_v[31:4]);
    ofs      = int'(a[3:2]);
    exp_dout = mdl_dout;
    exp_we   = 0;
    if (!hit) begin
      exp_lat  = 2;
      exp_dout = 32'd0;
    end else if (ofs == 3) begin
      exp_lat = 2;
      if (w) begin
        mdl_clr = d[6:4]; mdl_en_wr = 1'b1; mdl_en_new = d[2:0];
      end else begin
        exp_dout = {25'd0, mdl_pend, 1'b0, mdl_en};
      end
    end else if (w) begin
      exp_lat = WE_HOLD + 2;
      exp_we  = WE_HOLD;
    end else begin
      exp_lat  = RD_WAIT + 2;
      exp_dout = chan_val[ofs];
    end
    mem_w = w; mem_r = r; addr = a; data_in = d;
    n = 1;
    we_cnt = 0;
    while (n < 40) begin
      tick();
      n++;
      if (drop) begin mem_w = 1'b0; mem_r = 1'b0; end
      if (counter_we) begin
        we_cnt++;
        chk("ld_val", counter_val, d);
        chk("ld_ch", 32'(counter_ch), 32'(ofs));
      end
      if (cpu_ready) break;
    end
    chk("latency", n, exp_lat);
    chk("we_cycles", we_cnt, exp_we);
    chk("data_out", data_out, exp_dout);
    mdl_dout = exp_dout;
    mem_w = 1'b0; mem_r = 1'b0;
    tick();
    chk("ready_pulse", 32'(cpu_ready), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) chan_val[i] = $urandom;

    // Reset held with random inputs: every output must sit at zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_w = 1'($urandom); mem_r = 1'($urandom);
      addr = $urandom; data_in = $urandom; flg = 3'($urandom);
      #1;
      chk("rst_we", 32'(counter_we), 32'd0);
      chk("rst_val", counter_val, 32'd0);
      chk("rst_ch", 32'(counter_ch), 32'd0);
      chk("rst_dout", data_out, 32'd0);
      chk("rst_ready", 32'(cpu_ready), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
    end
    @(negedge clk);
    mem_w = 1'b0; mem_r = 1'b0; flg = 3'b000;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ready", 32'(cpu_ready), 32'd0);
      chk("idle_we", 32'(counter_we), 32'd0);
    end

    // Count write to channel 1.
    access(1'b1, 1'b0, BASE + 32'h4, 32'h0000_0010, 1'b0);
    // Count read of channel 2.
    chan_val[2] = 32'h1234_5678;
    access(1'b0, 1'b1, BASE + 32'h8, 32'h0, 1'b0);
    chk("rd_ch", 32'(counter_ch), 32'd2);
    chk("rd_data", data_out, 32'h1234_5678);

    // Enable channel 0 interrupt, raise its zero flag, read and clear.
    access(1'b1, 1'b0, BASE + 32'hC, 32'h1, 1'b0);
    flg[0] = 1'b1;
    tick();
    chk("irq_set", 32'(irq), 32'd1);
    access(1'b0, 1'b1, BASE + 32'hC, 32'h0, 1'b0);
    chk("ctrl_rd", data_out, 32'h0000_0011);
    access(1'b1, 1'b0, BASE + 32'hC, 32'h11, 1'b0);
    chk("irq_clr", 32'(irq), 32'd0);

    // Rising flag in the same cycle as its clear: the set must win.
    flg[1] = 1'b1;
    access(1'b1, 1'b0, BASE + 32'hC, 32'h20, 1'b0);
    access(1'b0, 1'b1, BASE + 32'hC, 32'h0, 1'b0);
    chk("set_wins", data_out, 32'h0000_0020);
    chk("irq_masked", 32'(irq), 32'd0);

    // Miss outside the window, then a read that returns after dropped request.
    access(1'b1, 1'b0, BASE + 32'h20, 32'hDEAD_BEEF, 1'b0);
    access(1'b0, 1'b1, BASE + 32'h0, 32'h0, 1'b1);

    // Reset during a load.
    mem_w = 1'b1; addr = BASE; data_in = 32'hCAFE_0001;
    tick();
    tick();
    chk("load_active", 32'(counter_we), 32'd1);
    mem_w = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_we_drop", 32'(counter_we), 32'd0);
    chk("rst_val_drop", counter_val, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_ready", 32'(cpu_ready), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_ready", 32'(cpu_ready), 32'd0);
      chk("post_rst_we", 32'(counter_we), 32'd0);
    end

    // Randomized mix of accesses with free-running zero flags.
    rand_flags = 1'b1;
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      int          rw;
      bit          w, r;
      for (int i = 0; i < 3; i++) chan_val[i] = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom;
        if (a[31:4] == base_v[31:4]) a[8] = 1'b0;
      end else begin
        a = BASE | 32'($urandom_range(0, 15));
      end
      rw = $urandom_range(0, 3);
      w  = (rw == 0) || (rw == 2);
      r  = (rw != 0);
      access(w, r, a, $urandom, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- CPU-side initiator for the three-channel down-counter/timer peripheral.
- Decodes CPU load/store accesses in the timer address window and drives the counter's write strobe, load value and channel select.
- Reads back the selected channel's count and converts the counter zero flags into maskable, sticky interrupt requests.
- Sits between the multi-cycle CPU memory stage and the counter peripheral. The CPU stalls on it via `cpu_ready`.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00, word-aligned base of the 16-byte register window.
- WE_HOLD, 4, cycles `counter_we` is held high per load (must cover at least 2 periods of the slowest counter clock); legal range 1..15.
- RD_WAIT, 2, cycles between driving `counter_ch` and sampling `counter_out`; legal range 1..7.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted
- mem_w  in  1  CPU store request, level, held until cpu_ready
- mem_r  in  1  CPU load request, level, held until cpu_ready
- addr  in  32  CPU byte address
- data_in  in  32  CPU store data
- data_out  out  32  load return data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse for the current access
- counter_we  out  1  counter load strobe
- counter_val  out  32  counter load value
- counter_ch  out  2  channel select, 0..2
- counter_out  in  32  selected channel count, registered by the counter
- counter0_out, counter1_out, counter2_out  in  1  channel-N-is-zero flags
- irq  out  1  OR of (pending & enable)

Behaviour:
- Address decode:
  - hit = (addr[31:4] == BASE_ADDR[31:4]); addr[1:0] ignored.
  - Offsets: 0x0/0x4/0x8 are channel 0/1/2 count (W = load, R = current count); 0xC is CTRL.
  - CTRL layout: [2:0] irq enable (RW); [6:4] pending (R, write-1-to-clear); other bits read 0, ignored on write.
- Reset values: counter_we=0, counter_val=0, counter_ch=0, data_out=0, cpu_ready=0, enable=0, pending=0, irq=0, FSM=IDLE, flag history=0.
- FSM states: IDLE, LOAD, RSEL, RWAIT, DONE.
- IDLE:
  - No request: remain in IDLE.
  - mem_w and mem_r both high: treat as a write.
  - Miss (no hit): go to DONE, data_out=0, no side effects.
  - Write to 0x0..0x8: latch counter_val=data_in and counter_ch=addr[3:2], go to LOAD.
  - Write to CTRL: update enable and clear pending bits in the same cycle, go to DONE.
  - Read of CTRL: load data_out, go to DONE.
  - Read of 0x0..0x8: set counter_ch, go to RSEL.
- LOAD: counter_we=1 for exactly WE_HOLD cycles, counter_val and counter_ch stable throughout, then counter_we=0 and go to DONE.
- RSEL / RWAIT: counter_ch held; wait RD_WAIT cycles total, then latch data_out=counter_out and go to DONE.
- DONE: cpu_ready=1 for one cycle, then IDLE. data_out holds its value until the next read.
- Latency, request-seen cycle to cpu_ready:
  - CTRL or miss: 2 cycles.
  - Count write: WE_HOLD+2 cycles.
  - Count read: RD_WAIT+2 cycles.
- Request dropped mid-access: ignored; the access completes.
- Interrupts:
  - Each clk, register counterN_out into a history bit.
  - Rising edge (flag=1, history=0) sets pendingN regardless of enable.
  - irq = |(pending & enable), combinational from registers.
- Simultaneous set and W1C clear of the same pending bit: set wins, bit stays 1.
- A channel load does not clear its pending bit.
- Reset asserted mid-operation: immediate return to reset values. An in-progress counter_we drops asynchronously and cpu_ready is not issued.
- Counter arithmetic belongs to the counter; this block passes the 32-bit load value unmodified.

Test Plan:
- Reset with reset=0 and random inputs -> all outputs 0, irq=0. Release reset, no requests -> FSM stays IDLE, cpu_ready=0.
- Store 32'h0000_0010 to BASE+0x4, WE_HOLD=4 -> counter_ch=1, counter_val=32'h10, counter_we high exactly 4 cycles, cpu_ready pulses 6 cycles after request.
- counter_out=32'h1234_5678 on channel 2, load BASE+0x8, RD_WAIT=2 -> counter_ch=2, data_out=32'h1234_5678 with cpu_ready 4 cycles after request.
- Store 0x1 to CTRL, then counter0_out 0->1 -> pending[0]=1 next cycle, irq=1. Load CTRL -> 32'h0000_0011. Store 0x11 -> pending clear, irq=0.
- counter1_out rising edge in the same cycle as a W1C of bit 5 -> pending[1] stays 1. With enable[1]=0 -> irq=0, pending still reads 1.
- Store to BASE+0x20 (miss) -> no counter_we, cpu_ready after 2 cycles. Assert reset during LOAD -> counter_we drops immediately, no cpu_ready, FSM IDLE after release.
